dmi_jtag_dr: RTL

Debug Module Interface (DMI) access data register. It sits directly downstream of the JTAG TAP controller and consumes the TAP's DR-scan strobes whenever the DMIACCESS instruction is selected. It holds the 41-bit DMI shift register and turns each completed scan into one request/response transaction toward the debug module. It returns the sticky DMI error status that the TAP reports in `dtmcs.dmistat`.

---
 rtl/dm_pkg.sv | 30 +++
 rtl/dmi_jtag_dr.sv | 102 ++++++++++
 2 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared debug-module interface types for the DTM and debug module
package dm_pkg;

    localparam int unsigned DmiAddrWidth = 7;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DTM_SUCCESS = 2'd0,
        DTM_ERR     = 2'd1,
        DTM_FAILED  = 2'd2,
        DTM_BUSY    = 2'd3
    } dtm_op_status_e;

    typedef struct packed {
        logic [DmiAddrWidth-1:0] addr;
        dtm_op_e                 op;
        logic [31:0]             data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_jtag_dr.sv
// dmi_jtag_dr: DMI access data register turning each DR scan into one DMI transaction
module dmi_jtag_dr
    import dm_pkg::*;
#(
    parameter int unsigned AddrWidth = DmiAddrWidth,
    parameter int unsigned DrWidth   = AddrWidth + 34
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 test_logic_reset_i,
    input  logic                 dmi_access_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 dmi_tdi_i,
    output logic                 dmi_tdo_o,
    input  logic                 dmi_reset_i,
    output dtm_op_status_e       dmi_error_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output dmi_req_t             dmi_req_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  dmi_resp_t            dmi_resp_i
);

    typedef enum logic [2:0] {Idle, Read, WaitRead, Write, WaitWrite} state_e;

    state_e               state_q, state_d;
    logic [DrWidth-1:0]   dr_q, dr_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    dtm_op_status_e       error_q, error_d, status;
    logic                 set_busy, set_failed;

    assign dmi_tdo_o   = dr_q[0];
    assign dmi_error_o = error_q;
    assign status      = error_q != DTM_SUCCESS ? error_q : state_q != Idle ? DTM_BUSY : DTM_SUCCESS;

    // next-state: transaction FSM, scan strobes and sticky error (first error wins, dmireset wins over all)
    always_comb begin
        state_d          = state_q;
        dr_d             = dr_q;
        addr_d           = addr_q;
        data_d           = data_q;
        set_busy         = 1'b0;
        set_failed       = 1'b0;
        dmi_req_valid_o  = state_q == Read || state_q == Write;
        dmi_resp_ready_o = !dmi_req_valid_o;
        dmi_req_o.addr   = addr_q;
        dmi_req_o.op     = state_q == Read ? DTM_READ : state_q == Write ? DTM_WRITE : DTM_NOP;
        dmi_req_o.data   = data_q;
        case (state_q)
            Read:  if (dmi_req_ready_i) state_d = WaitRead;
            Write: if (dmi_req_ready_i) state_d = WaitWrite;
            WaitRead, WaitWrite: begin
                if (dmi_resp_valid_i) begin
                    state_d    = Idle;
                    set_failed = dmi_resp_i.resp != 2'd0;
                    if (state_q == WaitRead) data_d = dmi_resp_i.data;
                end
            end
            default: ;
        endcase
        if (dmi_access_i) begin
            if (capture_dr_i) begin
                dr_d     = {addr_q, data_q, status};
                set_busy = state_q != Idle;
            end else if (shift_dr_i) begin
                dr_d = {dmi_tdi_i, dr_q[DrWidth-1:1]};
            end else if (update_dr_i) begin
                if (state_q != Idle) begin
                    set_busy = 1'b1;
                end else if (error_q == DTM_SUCCESS) begin
                    addr_d  = dr_q[DrWidth-1:34];
                    data_d  = dr_q[33:2];
                    state_d = dr_q[1:0] == DTM_READ ? Read : dr_q[1:0] == DTM_WRITE ? Write : Idle;
                end
            end
        end
        error_d = dmi_reset_i ? DTM_SUCCESS : error_q != DTM_SUCCESS ? error_q :
                  set_failed ? DTM_FAILED : set_busy ? DTM_BUSY : DTM_SUCCESS;
    end

    // state registers; TAP reset abandons any outstanding request
    always_ff @(posedge tck_i) begin
        if (!trst_ni || test_logic_reset_i) begin
            state_q <= Idle;
            dr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= DTM_SUCCESS;
        end else begin
            state_q <= state_d;
            dr_q    <= dr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

endmodule
